branch_predictor_update: RTL and testbench

Write-side stage directly upstream of the branch predictor RAM; it owns that RAM's write port.
- Accepts branch resolutions from execute, computes new 2-bit saturating counter, tag and target, and issues single-cycle RAM writes.
- Runs a post-reset/flush clearing sweep, because the RAM has no reset.
- Buffers resolutions in a small FIFO while the write port is busy.

---
 rtl/branch_predictor_update_pkg.sv | 48 ++++
 rtl/branch_update_fifo.sv | 65 ++++++
 rtl/branch_predictor_update.sv | 165 ++++++++++++++++
 tb/tb_branch_predictor_update.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_update_pkg.sv
// Shared types and helpers for the branch predictor write-side stage.
// Optional feature macro: BRANCH_PREDICTOR_UPDATE_FILTER_EN (see top).
package branch_predictor_update_pkg;

  // Counter value written when a taken branch allocates a fresh entry
  localparam logic [1:0] BRANCH_COUNTER_ALLOC = 2'b10;

  // Tag width of the default table configuration
  localparam int BP_DEFAULT_TAG_WIDTH = 16;

  // One predictor table entry at the default tag width
  typedef struct packed {
    logic                            valid;
    logic [BP_DEFAULT_TAG_WIDTH-1:0] tag;
    logic [29:0]                     target;
    logic [1:0]                      counter;
  } branch_table_entry_t;

  // One branch resolution as delivered by execute
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        prev_hit;
    logic [1:0]  prev_counter;
  } branch_resolution_t;

  localparam int BP_RESOLUTION_W = $bits(branch_resolution_t);

  // Sweep-then-run control states
  typedef enum logic {
    ST_INIT,
    ST_RUN
  } bpu_state_e;

  // Two-bit saturating counter step in the direction of the outcome
  function automatic logic [1:0] next_counter(input logic [1:0] prev, input logic taken);
    logic [1:0] result;
    result = prev;
    if (taken) begin
      if (prev != 2'b11) result = prev + 2'b01;
    end else begin
      if (prev != 2'b00) result = prev - 2'b01;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// Small resolution buffer in front of the predictor RAM write port.
// Depth is a power of two; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module branch_update_fifo
  import branch_predictor_update_pkg::*;
#(
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [BP_RESOLUTION_W-1:0] push_data_i,
  input  logic                       pop_i,
  output logic [BP_RESOLUTION_W-1:0] pop_data_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(C_FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [BP_RESOLUTION_W-1:0] mem_q [C_FIFO_DEPTH];
  logic [PTR_W:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]             rd_ptr_q, rd_ptr_d;
  logic                       do_push;
  logic                       do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push    = push_i && !full_o && !clear_i;
  assign do_pop     = pop_i && !empty_o && !clear_i;
  assign pop_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointer advance; clear wins over any push or pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/branch_predictor_update.sv
// Write-side stage owning the branch predictor RAM write port.
// Clears the table after reset/flush, then turns buffered branch
// resolutions into single-cycle RAM writes.
// Optional: define BRANCH_PREDICTOR_UPDATE_FILTER_EN to skip writes of
// not-taken hits whose counter is already saturated at zero.
module branch_predictor_update
  import branch_predictor_update_pkg::*;
#(
  parameter  int C_DEPTH      = 512,
  parameter  int C_TAG_WIDTH  = 16,
  parameter  int C_FIFO_DEPTH = 4,
  localparam int IDX_W        = $clog2(C_DEPTH),
  localparam int C_DATA_WIDTH = 1 + C_TAG_WIDTH + 30 + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    resolve_valid,
  output logic                    resolve_ready,
  input  logic [31:0]             resolve_pc,
  input  logic                    resolve_taken,
  input  logic [31:0]             resolve_target,
  input  logic                    resolve_prev_hit,
  input  logic [1:0]              resolve_prev_counter,
  output logic [IDX_W-1:0]        write_addr,
  output logic                    write_en,
  output logic [C_DATA_WIDTH-1:0] write_data,
  output logic                    init_done
);

  localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(C_DEPTH - 1);
  localparam logic [IDX_W-1:0] SWEEP_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                   valid;
    logic [C_TAG_WIDTH-1:0] tag;
    logic [29:0]            target;
    logic [1:0]             counter;
  } entry_t;

  bpu_state_e              state_q, state_d;
  logic [IDX_W-1:0]        sweep_q, sweep_d;
  logic                    init_done_q, init_done_d;
  logic                    write_en_q, write_en_d;
  logic [IDX_W-1:0]        write_addr_q, write_addr_d;
  logic [C_DATA_WIDTH-1:0] write_data_q, write_data_d;

  branch_resolution_t          in_res;
  branch_resolution_t          head;
  logic [BP_RESOLUTION_W-1:0]  fifo_pop_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  logic                        upd_write;
  logic [1:0]                  upd_counter;
  entry_t                      upd_entry;
  logic                        unused_ok;

  assign in_res = '{pc:           resolve_pc,
                    taken:        resolve_taken,
                    target:       resolve_target,
                    prev_hit:     resolve_prev_hit,
                    prev_counter: resolve_prev_counter};

  assign resolve_ready = rst && !fifo_full && !flush;
  assign push          = resolve_valid && resolve_ready;
  assign pop           = (state_q == ST_RUN) && !fifo_empty && !flush;
  assign head          = branch_resolution_t'(fifo_pop_data);
  assign unused_ok     = ^{head.pc, head.target[1:0]};

  branch_update_fifo #(
    .C_FIFO_DEPTH(C_FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clear_i    (flush),
    .push_i     (push),
    .push_data_i(in_res),
    .pop_i      (pop),
    .pop_data_o (fifo_pop_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // New entry for the head resolution and whether it needs a RAM write at all
  always_comb begin
    upd_write   = 1'b0;
    upd_counter = BRANCH_COUNTER_ALLOC;
    if (head.prev_hit) begin
      upd_counter = next_counter(head.prev_counter, head.taken);
      upd_write   = 1'b1;
`ifdef BRANCH_PREDICTOR_UPDATE_FILTER_EN
      if (!head.taken && (upd_counter == head.prev_counter)) upd_write = 1'b0;
`endif
    end else if (head.taken) begin
      upd_counter = BRANCH_COUNTER_ALLOC;
      upd_write   = 1'b1;
    end
    upd_entry = '{valid:   1'b1,
                  tag:     head.pc[IDX_W+2 +: C_TAG_WIDTH],
                  target:  head.target[31:2],
                  counter: upd_counter};
  end

  // Sweep/run sequencing and the next values of the registered RAM port
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    init_done_d  = init_done_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (flush) begin
      state_d     = ST_INIT;
      sweep_d     = '0;
      init_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          write_en_d   = 1'b1;
          write_addr_d = sweep_q;
          write_data_d = '0;
          sweep_d      = sweep_q + SWEEP_ONE;
          init_done_d  = 1'b0;
          if (sweep_q == SWEEP_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          init_done_d = 1'b1;
          if (pop && upd_write) begin
            write_en_d   = 1'b1;
            write_addr_d = head.pc[IDX_W+1:2];
            write_data_d = upd_entry;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // State and RAM-port registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      init_done_q  <= 1'b0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      init_done_q  <= init_done_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_branch_predictor_update.sv
// Self-checking bench for branch_predictor_update: directed scenarios plus
// randomized resolutions compared against a queue-based behavioural model.
module tb_branch_predictor_update;

  localparam int DEPTH = 512;
  localparam int TAG   = 16;
  localparam int FD    = 4;
  localparam int IDX_W = 9;
  localparam int DW    = 1 + TAG + 30 + 2;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        hit;
    logic [1:0]  prev;
  } res_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              resolve_valid;
  logic              resolve_ready;
  logic [31:0]       resolve_pc;
  logic              resolve_taken;
  logic [31:0]       resolve_target;
  logic              resolve_prev_hit;
  logic [1:0]        resolve_prev_counter;
  logic [IDX_W-1:0]  write_addr;
  logic              write_en;
  logic [DW-1:0]     write_data;
  logic              init_done;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  res_t          m_fifo[$];
  bit            m_init;
  int            m_sweep;
  bit            m_done;
  bit            e_en;
  int            e_addr;
  logic [DW-1:0] e_data;

  // Last DUT samples, used for directed counting
  bit last_ready;
  bit last_en;

  res_t idle_res;
  bit   acc;

  branch_predictor_update #(
    .C_DEPTH     (DEPTH),
    .C_TAG_WIDTH (TAG),
    .C_FIFO_DEPTH(FD)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .resolve_valid       (resolve_valid),
    .resolve_ready       (resolve_ready),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_prev_hit    (resolve_prev_hit),
    .resolve_prev_counter(resolve_prev_counter),
    .write_addr          (write_addr),
    .write_en            (write_en),
    .write_data          (write_data),
    .init_done           (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected RAM write for a popped resolution, straight from the update rules
  function automatic void modelWrite(input res_t h, output bit en, output int addr,
                                     output logic [DW-1:0] data);
    int c;
    logic [TAG-1:0] t;
    en = 1'b0;
    c  = int'(h.prev);
    if (h.hit) begin
      c  = h.taken ? c + 1 : c - 1;
      if (c > 3) c = 3;
      if (c < 0) c = 0;
      en = 1'b1;
`ifdef BRANCH_PREDICTOR_UPDATE_FILTER_EN
      if (!h.taken && h.prev == 2'd0) en = 1'b0;
`endif
    end else if (h.taken) begin
      c  = 2;
      en = 1'b1;
    end
    addr = int'((h.pc / 4) % DEPTH);
    t    = TAG'(h.pc >> (IDX_W + 2));
    data = {1'b1, t, h.target[31:2], 2'(c)};
  endfunction

  function automatic res_t randomRes(input bit force_taken);
    res_t r;
    r.pc     = $urandom;
    r.taken  = force_taken ? 1'b1 : 1'($urandom_range(0, 1));
    r.target = $urandom;
    r.hit    = 1'($urandom_range(0, 1));
    r.prev   = 2'($urandom_range(0, 3));
    return r;
  endfunction

  function automatic res_t makeRes(input logic [31:0] pc, input bit taken, input logic [31:0] target,
                                   input bit hit, input logic [1:0] prev);
    res_t r;
    r.pc = pc; r.taken = taken; r.target = target; r.hit = hit; r.prev = prev;
    return r;
  endfunction

  task automatic modelReset();
    m_fifo.delete();
    m_init  = 1'b1;
    m_sweep = 0;
    m_done  = 1'b0;
    e_en    = 1'b0;
  endtask

  // One clock cycle: drive, check ready, advance model, check registered outputs
  task automatic applyStimulus(input bit v, input res_t r, input bit fl, output bit accepted);
    bit   rdy_exp;
    res_t h;
    resolve_valid        = v;
    resolve_pc           = r.pc;
    resolve_taken        = r.taken;
    resolve_target       = r.target;
    resolve_prev_hit     = r.hit;
    resolve_prev_counter = r.prev;
    flush                = fl;
    #1;
    rdy_exp    = (m_fifo.size() < FD) && !fl;
    last_ready = resolve_ready;
    checkOutput("resolve_ready", 64'(resolve_ready), 64'(rdy_exp));
    accepted = v && rdy_exp;
    if (fl) begin
      m_fifo.delete();
      m_init  = 1'b1;
      m_sweep = 0;
      m_done  = 1'b0;
      e_en    = 1'b0;
    end else if (m_init) begin
      e_en   = 1'b1;
      e_addr = m_sweep;
      e_data = '0;
      m_done = 1'b0;
      if (m_sweep == DEPTH - 1) m_init = 1'b0;
      else m_sweep++;
    end else begin
      m_done = 1'b1;
      e_en   = 1'b0;
      if (m_fifo.size() > 0) begin
        h = m_fifo.pop_front();
        modelWrite(h, e_en, e_addr, e_data);
      end
    end
    if (accepted) m_fifo.push_back(r);
    @(posedge clk);
    #1;
    last_en = write_en;
    checkOutput("write_en", 64'(write_en), 64'(e_en));
    if (e_en) begin
      checkOutput("write_addr", 64'(write_addr), 64'(e_addr));
      checkOutput("write_data", 64'(write_data), 64'(e_data));
    end
    checkOutput("init_done", 64'(init_done), 64'(m_done));
    resolve_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    bit a;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, idle_res, 1'b0, a);
  endtask

  initial begin
    res_t pend[$];
    res_t r;
    int   cnt;
    int   guard;

    idle_res             = makeRes(32'h0, 1'b0, 32'h0, 1'b0, 2'd0);
    rst                  = 1'b1;
    flush                = 1'b0;
    resolve_valid        = 1'b0;
    resolve_pc           = '0;
    resolve_taken        = 1'b0;
    resolve_target       = '0;
    resolve_prev_hit     = 1'b0;
    resolve_prev_counter = '0;
    #2 rst = 1'b0;

    // Reset values, with a resolution offered during reset
    repeat (2) @(posedge clk);
    #1 resolve_valid = 1'b1;
    #1;
    checkOutput("reset_ready", 64'(resolve_ready), 64'd0);
    checkOutput("reset_write_en", 64'(write_en), 64'd0);
    checkOutput("reset_write_addr", 64'(write_addr), 64'd0);
    checkOutput("reset_write_data", 64'(write_data), 64'd0);
    checkOutput("reset_init_done", 64'(init_done), 64'd0);
    resolve_valid = 1'b0;
    rst = 1'b1;
    modelReset();

    // Six resolutions offered from the first sweep cycle; four fit in the FIFO
    for (int i = 0; i < 6; i++) pend.push_back(randomRes(1'b1));
    cnt = 0;
    for (int i = 0; i < DEPTH + 12; i++) begin
      if (pend.size() > 0) begin
        applyStimulus(1'b1, pend[0], 1'b0, acc);
        if (acc) void'(pend.pop_front());
      end else begin
        applyStimulus(1'b0, idle_res, 1'b0, acc);
      end
      if (i < 6 && last_ready) cnt++;
      if (i == 5) checkOutput("fill_ready_cycles", 64'(cnt), 64'd4);
    end
    checkOutput("fill_all_accepted", 64'(pend.size()), 64'd0);
    idleCycles(3);

    // Miss & taken at pc 0x1008: write two cycles later at index 2
    applyStimulus(1'b1, makeRes(32'h0000_1008, 1'b1, 32'h0000_2000, 1'b0, 2'd0), 1'b0, acc);
    applyStimulus(1'b0, idle_res, 1'b0, acc);
    checkOutput("alloc_en", 64'(write_en), 64'd1);
    checkOutput("alloc_addr", 64'(write_addr), 64'd2);
    checkOutput("alloc_data", 64'(write_data), 64'({1'b1, 16'h0002, 30'h800, 2'b10}));
    idleCycles(1);

    // Hit, counter already 3, taken: stays 3
    applyStimulus(1'b1, makeRes(32'h0000_4444, 1'b1, 32'h0000_8888, 1'b1, 2'd3), 1'b0, acc);
    applyStimulus(1'b0, idle_res, 1'b0, acc);
    checkOutput("sat_up_en", 64'(write_en), 64'd1);
    checkOutput("sat_up_counter", 64'(write_data[1:0]), 64'd3);
    idleCycles(1);

    // Hit, counter 0, not taken: stays 0 (or skipped when filtering)
    applyStimulus(1'b1, makeRes(32'h0000_5550, 1'b0, 32'h0000_1230, 1'b1, 2'd0), 1'b0, acc);
    applyStimulus(1'b0, idle_res, 1'b0, acc);
`ifdef BRANCH_PREDICTOR_UPDATE_FILTER_EN
    checkOutput("sat_down_filtered", 64'(write_en), 64'd0);
`else
    checkOutput("sat_down_en", 64'(write_en), 64'd1);
    checkOutput("sat_down_counter", 64'(write_data[1:0]), 64'd0);
`endif
    idleCycles(1);

    // Miss & not taken is dropped; the following entry writes the next cycle
    applyStimulus(1'b1, makeRes(32'h0000_0100, 1'b0, 32'h0000_0200, 1'b0, 2'd1), 1'b0, acc);
    applyStimulus(1'b1, makeRes(32'h0000_0300, 1'b1, 32'h0000_0400, 1'b0, 2'd0), 1'b0, acc);
    checkOutput("drop_no_write", 64'(write_en), 64'd0);
    applyStimulus(1'b0, idle_res, 1'b0, acc);
    checkOutput("after_drop_addr", 64'(write_addr), 64'd192);
    idleCycles(1);

    // Same index back to back: written in order
    applyStimulus(1'b1, makeRes(32'h0000_0A00, 1'b1, 32'h0000_1000, 1'b1, 2'd1), 1'b0, acc);
    applyStimulus(1'b1, makeRes(32'h0000_0A00, 1'b0, 32'h0000_1000, 1'b1, 2'd2), 1'b0, acc);
    idleCycles(3);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      r = randomRes(1'b0);
      applyStimulus(1'($urandom_range(0, 3) != 0), r, $urandom_range(0, 99) == 0, acc);
    end
    guard = 0;
    while ((m_init || m_fifo.size() > 0) && guard < 2 * DEPTH) begin
      idleCycles(1);
      guard++;
    end
    checkOutput("random_drain_bound", 64'(guard < 2 * DEPTH), 64'd1);

    // Flush at sweep address 100 with two entries buffered
    applyStimulus(1'b0, idle_res, 1'b1, acc);
    applyStimulus(1'b1, randomRes(1'b1), 1'b0, acc);
    applyStimulus(1'b1, randomRes(1'b1), 1'b0, acc);
    guard = 0;
    while (m_sweep != 100 && guard < DEPTH) begin
      idleCycles(1);
      guard++;
    end
    checkOutput("flush_reach_100", 64'(m_sweep), 64'd100);
    applyStimulus(1'b0, idle_res, 1'b1, acc);
    checkOutput("flush_cycle_en", 64'(write_en), 64'd0);
    applyStimulus(1'b0, idle_res, 1'b0, acc);
    checkOutput("flush_restart_addr", 64'(write_addr), 64'd0);
    idleCycles(DEPTH - 1);
    checkOutput("flush_sweep_last", 64'(write_addr), 64'(DEPTH - 1));
    checkOutput("flush_not_done_yet", 64'(init_done), 64'd0);
    idleCycles(2);
    checkOutput("flush_done", 64'(init_done), 64'd1);

    // Reset asserted mid-sweep returns to reset values immediately
    applyStimulus(1'b0, idle_res, 1'b1, acc);
    applyStimulus(1'b1, randomRes(1'b1), 1'b0, acc);
    idleCycles(50);
    rst = 1'b0;
    #1;
    checkOutput("midreset_en", 64'(write_en), 64'd0);
    checkOutput("midreset_addr", 64'(write_addr), 64'd0);
    checkOutput("midreset_ready", 64'(resolve_ready), 64'd0);
    checkOutput("midreset_done", 64'(init_done), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    modelReset();
    applyStimulus(1'b1, randomRes(1'b1), 1'b0, acc);
    idleCycles(DEPTH + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
